// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and precise-exception commit point.
// Commits exceptions/ERET, runs the Count/Compare timer and serves MTC0/MFC0.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    input  logic [31:0]         wb_pc,
    input  logic [31:0]         wb_badvaddr,
    input  logic [4:0]          wb_excCode,
    input  logic                wb_is_exc,
    input  logic                wb_is_in_ds,
    input  logic                wb_is_eret,
    input  logic                mtc0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         mtc0_wdata,
    output logic [31:0]         mfc0_rdata,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic                exc_occur,
    output logic                eret_occur,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         cp0_Status,
    output logic [31:0]         cp0_EPC
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] EXC_ADEL      = 5'h04;
    localparam logic [4:0] EXC_ADES      = 5'h05;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_ip_hw;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;

    logic [7:0]  w_ip;
    logic        w_int_pending;
    logic        w_take_int;
    logic        w_take_exc;
    logic [4:0]  w_exc_code;
    logic        w_do_eret;
    logic        w_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic [31:0] w_count_inc;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_exc_out;
    logic        w_eret_out;
    logic        w_unused;

    // IP7 is the timer; hw_int[5] shares that line and is dropped.
    assign w_unused      = ^hw_int[HW_INT_W-1:5];
    assign w_ip          = {r_ti, r_ip_hw, r_ip_sw};
    assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_take_int    = wb_valid & w_int_pending;
    assign w_take_exc    = wb_valid & (w_int_pending | wb_is_exc);
    assign w_exc_code    = w_take_int ? 5'd0 : wb_excCode;
    assign w_do_eret     = wb_valid & wb_is_eret & ~w_take_exc;
    assign w_mtc0        = mtc0_we & wb_valid & ~w_take_exc;
    assign w_wr_count    = w_mtc0 & (cp0_addr == ADDR_COUNT);
    assign w_wr_compare  = w_mtc0 & (cp0_addr == ADDR_COMPARE);
    assign w_count_inc   = r_count + 32'd1;

    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};

    // Commit pulses drop as soon as reset rises, even mid-cycle.
    assign w_exc_out   = w_take_exc & ~reset;
    assign w_eret_out  = w_do_eret & ~reset;
    assign exc_occur   = w_exc_out;
    assign eret_occur  = w_eret_out;
    assign redirect_pc = w_exc_out  ? EXC_VECTOR :
                         w_eret_out ? r_epc      : 32'd0;
    assign cp0_Status  = w_status;
    assign cp0_EPC     = r_epc;

    always_comb begin
        mfc0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_BADVADDR: mfc0_rdata = r_badvaddr;
            ADDR_COUNT:    mfc0_rdata = r_count;
            ADDR_COMPARE:  mfc0_rdata = r_compare;
            ADDR_STATUS:   mfc0_rdata = w_status;
            ADDR_CAUSE:    mfc0_rdata = w_cause;
            ADDR_EPC:      mfc0_rdata = r_epc;
            default:       mfc0_rdata = 32'd0;
        endcase
    end

    // A nested exception (EXL already set) keeps the original EPC and BD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_sw    <= 2'd0;
            r_ip_hw    <= 5'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            r_ip_hw <= hw_int[4:0];
            if (w_take_exc) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_exc_code;
                if (!r_exl) begin
                    r_epc <= wb_is_in_ds ? (wb_pc - 32'd4) : wb_pc;
                    r_bd  <= wb_is_in_ds;
                end
                if ((w_exc_code == EXC_ADEL) || (w_exc_code == EXC_ADES)) begin
                    r_badvaddr <= wb_badvaddr;
                end
            end else if (w_do_eret) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (cp0_addr)
                    ADDR_STATUS: begin
                        r_im  <= mtc0_wdata[15:8];
                        r_exl <= mtc0_wdata[1];
                        r_ie  <= mtc0_wdata[0];
                    end
                    ADDR_CAUSE: r_ip_sw <= mtc0_wdata[9:8];
                    ADDR_EPC:   r_epc   <= mtc0_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Count advances every other cycle; a Compare write beats a same-cycle match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_toggle  <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            r_toggle <= w_wr_count ? 1'b0 : ~r_toggle;
            if (w_wr_count) begin
                r_count <= mtc0_wdata;
            end else if (r_toggle) begin
                r_count <= w_count_inc;
            end
            if (w_wr_compare) begin
                r_compare <= mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (r_toggle && !w_wr_count && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: vector table plus timer/reset sequences,
// with expectations queued on a scoreboard and compared before each commit edge.
module tb_cp0_regfile;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic [4:0]  wb_excCode;
    logic        wb_is_exc;
    logic        wb_is_in_ds;
    logic        wb_is_eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic [5:0]  hw_int;
    logic        exc_occur;
    logic        eret_occur;
    logic [31:0] redirect_pc;
    logic [31:0] cp0_Status;
    logic [31:0] cp0_EPC;

    cp0_regfile #(.EXC_VECTOR(VEC), .HW_INT_W(6)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .wb_excCode(wb_excCode), .wb_is_exc(wb_is_exc),
        .wb_is_in_ds(wb_is_in_ds), .wb_is_eret(wb_is_eret), .mtc0_we(mtc0_we),
        .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata), .mfc0_rdata(mfc0_rdata),
        .hw_int(hw_int), .exc_occur(exc_occur), .eret_occur(eret_occur),
        .redirect_pc(redirect_pc), .cp0_Status(cp0_Status), .cp0_EPC(cp0_EPC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {K_EXC, K_ERET, K_REDIR, K_RDATA, K_STATUS, K_EPC} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [4:0]  code;
        logic        isExc;
        logic        inDs;
        logic        isEret;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  hw;
        logic        expExc;
        logic        expEret;
        logic [31:0] expRedir;
        logic [31:0] expRdata;
        logic        chkRd;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input string name, input logic valid, input logic [31:0] pc,
                                input logic [31:0] bad, input logic [4:0] code, input logic isExc,
                                input logic inDs, input logic isEret, input logic we,
                                input logic [4:0] addr, input logic [31:0] wdata, input logic [5:0] hw,
                                input logic expExc, input logic expEret, input logic [31:0] expRedir,
                                input logic [31:0] expRdata, input logic chkRd = 1'b1);
        vec_t v;
        v.name = name; v.valid = valid; v.pc = pc; v.bad = bad; v.code = code;
        v.isExc = isExc; v.inDs = inDs; v.isEret = isEret; v.we = we; v.addr = addr;
        v.wdata = wdata; v.hw = hw; v.expExc = expExc; v.expEret = expEret;
        v.expRedir = expRedir; v.expRdata = expRdata; v.chkRd = chkRd;
        return v;
    endfunction

    function automatic vec_t rd(input string name, input logic [4:0] addr, input logic [31:0] expRdata);
        return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, addr, 0, 0, 0, 0, 0, expRdata);
    endfunction

    task automatic pushExp(input string name, input kind_t kind, input logic [31:0] exp);
        sb_t e;
        e.name = name; e.kind = kind; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic driveInputs(input vec_t v);
        wb_valid = v.valid; wb_pc = v.pc; wb_badvaddr = v.bad; wb_excCode = v.code;
        wb_is_exc = v.isExc; wb_is_in_ds = v.inDs; wb_is_eret = v.isEret;
        mtc0_we = v.we; cp0_addr = v.addr; mtc0_wdata = v.wdata; hw_int = v.hw;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v);
        #2;
    endtask

    task automatic checkOutput();
        sb_t         e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_EXC:    got = {31'd0, exc_occur};
                K_ERET:   got = {31'd0, eret_occur};
                K_REDIR:  got = redirect_pc;
                K_RDATA:  got = mfc0_rdata;
                K_STATUS: got = cp0_Status;
                default:  got = cp0_EPC;
            endcase
            checks++;
            if (got !== e.exp) begin
                failures++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        pushExp({v.name, ".exc"}, K_EXC, {31'd0, v.expExc});
        pushExp({v.name, ".eret"}, K_ERET, {31'd0, v.expEret});
        pushExp({v.name, ".redir"}, K_REDIR, v.expRedir);
        if (v.chkRd) pushExp({v.name, ".rdata"}, K_RDATA, v.expRdata);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        driveInputs(rd("init", 0, 0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        vecs.push_back(rd("rst_status", 12, 32'h0040_0000));
        vecs.push_back(rd("rst_cause", 13, 32'h0000_0000));
        vecs.push_back(rd("rst_epc", 14, 32'h0000_0000));
        vecs.push_back(mk("ov_commit", 1, 32'hBFC0_1000, 0, 5'h0C, 1, 0, 0, 0, 14, 0, 0, 1, 0, VEC, 32'h0));
        vecs.push_back(rd("ov_epc", 14, 32'hBFC0_1000));
        vecs.push_back(rd("ov_cause", 13, 32'h0000_0030));
        vecs.push_back(rd("ov_status", 12, 32'h0040_0002));
        vecs.push_back(mk("eret1", 1, 0, 0, 0, 0, 0, 1, 0, 12, 0, 0, 0, 1, 32'hBFC0_1000, 32'h0040_0002));
        vecs.push_back(rd("eret1_status", 12, 32'h0040_0000));
        vecs.push_back(mk("adel_ds", 1, 32'h8000_0104, 32'h0000_0003, 5'h04, 1, 1, 0, 0, 8, 0, 0, 1, 0, VEC, 32'h0));
        vecs.push_back(rd("adel_epc", 14, 32'h8000_0100));
        vecs.push_back(rd("adel_cause", 13, 32'h8000_0010));
        vecs.push_back(rd("adel_badv", 8, 32'h0000_0003));
        vecs.push_back(mk("nested_exc", 1, 32'h9000_0000, 32'hDEAD_0000, 5'h0A, 1, 0, 0, 0, 14, 0, 0, 1, 0, VEC, 32'h8000_0100));
        vecs.push_back(rd("nested_epc", 14, 32'h8000_0100));
        vecs.push_back(rd("nested_cause", 13, 32'h8000_0028));
        vecs.push_back(rd("nested_badv", 8, 32'h0000_0003));
        vecs.push_back(mk("mtc0_epc", 1, 0, 0, 0, 0, 0, 0, 1, 14, 32'h8000_0200, 0, 0, 0, 0, 32'h8000_0100));
        vecs.push_back(mk("eret2", 1, 0, 0, 0, 0, 0, 1, 0, 14, 0, 0, 0, 1, 32'h8000_0200, 32'h8000_0200));
        vecs.push_back(rd("eret2_status", 12, 32'h0040_0000));
        vecs.push_back(mk("mtc0_vs_exc", 1, 32'h8000_0300, 0, 5'h08, 1, 0, 0, 1, 12, 32'h0000_FF01, 0, 1, 0, VEC, 32'h0040_0000));
        vecs.push_back(rd("drop_status", 12, 32'h0040_0002));
        vecs.push_back(rd("drop_epc", 14, 32'h8000_0300));
        vecs.push_back(rd("drop_cause", 13, 32'h0000_0020));
        vecs.push_back(mk("mtc0_badv", 1, 0, 0, 0, 0, 0, 0, 1, 8, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0000_0003));
        vecs.push_back(rd("badv_ro", 8, 32'h0000_0003));
        vecs.push_back(mk("mtc0_cause", 1, 0, 0, 0, 0, 0, 0, 1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0000_0020));
        vecs.push_back(mk("mtc0_cause_clr", 1, 0, 0, 0, 0, 0, 0, 1, 13, 32'h0, 0, 0, 0, 0, 32'h0000_0320));
        vecs.push_back(rd("cause_sw_clr", 13, 32'h0000_0020));
        vecs.push_back(rd("unimpl_reg", 3, 32'h0));
        vecs.push_back(mk("hw_int0", 0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 6'h01, 0, 0, 0, 32'h0000_0020));
        vecs.push_back(mk("hw_int5", 0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 6'h20, 0, 0, 0, 32'h0000_0420));
        vecs.push_back(rd("hw_int_off", 13, 32'h0000_0020));

        foreach (vecs[i]) runVec(vecs[i]);

        // Timer: Count=0, Compare=5, enable IM7+IE; TI sets once Count reaches 5
        runVec(mk("t_cnt0", 1, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0, 0, 0, 0, 0, 0, 1'b0));
        runVec(mk("t_cmp5", 1, 0, 0, 0, 0, 0, 0, 1, 11, 32'h5, 0, 0, 0, 0, 32'h0));
        runVec(mk("t_status", 1, 0, 0, 0, 0, 0, 0, 1, 12, 32'h0000_8001, 0, 0, 0, 0, 32'h0040_0002));
        runVec(rd("t_status_rd", 12, 32'h0040_8001));
        for (int i = 0; i < 6; i++) runVec(rd("t_wait", 13, 32'h0000_0020));
        runVec(rd("t_count4", 9, 32'h4));
        runVec(rd("t_ti_set", 13, 32'h4000_8020));
        runVec(mk("t_int", 1, 32'h8000_0400, 0, 0, 0, 0, 0, 0, 13, 0, 0, 1, 0, VEC, 32'h4000_8020));
        runVec(mk("t_cmp_clr", 1, 0, 0, 0, 0, 0, 0, 1, 11, 32'h100, 0, 0, 0, 0, 32'h5));
        runVec(rd("t_cause_clr", 13, 32'h0));
        pushExp("t_status_out", K_STATUS, 32'h0040_8003);
        pushExp("t_epc_out", K_EPC, 32'h8000_0400);
        checkOutput();

        // Count wraps from all-ones
        runVec(mk("w_cnt_max", 1, 0, 0, 0, 0, 0, 0, 1, 9, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1'b0));
        runVec(rd("w_hold0", 9, 32'hFFFF_FFFF));
        runVec(rd("w_hold1", 9, 32'hFFFF_FFFF));
        runVec(rd("w_wrapped", 9, 32'h0));

        // Reset asserted in the middle of an excepting commit
        applyStimulus(mk("r_mid", 1, 32'h8000_0500, 0, 5'h0C, 1, 0, 0, 0, 12, 0, 0, 1, 0, VEC, 0));
        reset = 1'b1;
        #1;
        pushExp("r_mid.exc", K_EXC, 32'h0);
        pushExp("r_mid.redir", K_REDIR, 32'h0);
        pushExp("r_mid.status", K_RDATA, 32'h0040_0000);
        pushExp("r_mid.epc", K_EPC, 32'h0);
        checkOutput();
        @(negedge clk);
        driveInputs(rd("r_idle", 0, 0));
        reset = 1'b0;
        runVec(rd("r_epc", 14, 32'h0));
        runVec(rd("r_compare", 11, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception commit point, at the write-back end of the CP0 exception pipeline.
- Consumes the exception record carried down the pipeline (pc, badvaddr, excCode, is_exc, is_in_ds, is_eret) and samples hardware interrupts.
- Commits precise exceptions and ERET into Status/Cause/EPC/BadVAddr, runs the Count/Compare timer, and serves MTC0/MFC0.
- Produces the flush/redirect pulse (exc_occur) and the cp0_Status/cp0_EPC values fed back to the upstream exception stages.

Parameters:
EXC_VECTOR  32'hBFC0_0380  redirect target for all exceptions and interrupts
HW_INT_W    6              number of hardware interrupt lines (IP7..IP2)

Ports:
clk          in   1         clock
reset        in   1         asynchronous, active-high reset
wb_valid     in   1         committing instruction valid this cycle
wb_pc        in   32        raw PC of committing instruction
wb_badvaddr  in   32        faulting address for AdEL/AdES
wb_excCode   in   5         exception code (valid when wb_is_exc)
wb_is_exc    in   1         instruction raised an exception
wb_is_in_ds  in   1         instruction is in a branch delay slot
wb_is_eret   in   1         instruction is ERET
mtc0_we      in   1         MTC0 write request (qualified by wb_valid)
cp0_addr     in   5         register number for MTC0/MFC0 (sel 0 only)
mtc0_wdata   in   32        MTC0 data
mfc0_rdata   out  32        combinational read of cp0_addr
hw_int       in   HW_INT_W  level-sensitive external interrupts
exc_occur    out  1         one-cycle flush pulse: exception/interrupt taken
eret_occur   out  1         one-cycle pulse: ERET committed
redirect_pc  out  32        EXC_VECTOR when exc_occur, EPC when eret_occur, else 0
cp0_Status   out  32        current Status
cp0_EPC      out  32        current EPC

Behaviour:
- Reset values (async, on reset assertion):
  - Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare and the count toggle bit = 0.
  - exc_occur = 0, eret_occur = 0.
- Implemented registers (reads of any other number return 0):
  - BadVAddr(8): read-only.
  - Count(9), Compare(11): full 32-bit R/W.
  - Status(12): writable IM[15:8], EXL[1], IE[0]; BEV reads 1; all other bits read 0.
  - Cause(13): BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] writable.
  - EPC(14): full 32-bit R/W.
- Cause.IP[15:10] = {TI, hw_int[4:0]} sampled every cycle; hw_int[5] is ignored (shared with the timer).
- int_pending = IE & !EXL & |(IP & IM).
- take_int = wb_valid & int_pending; an interrupt outranks any instruction exception or ERET on the same instruction.
- take_exc = wb_valid & (take_int | wb_is_exc).
- On take_exc, effective next edge:
  - ExcCode = 0 if take_int, else wb_excCode.
  - If EXL was 0: EPC = wb_is_in_ds ? wb_pc-4 : wb_pc; BD = wb_is_in_ds.
  - If EXL was 1: EPC and BD unchanged.
  - EXL = 1.
  - BadVAddr = wb_badvaddr only when ExcCode is AdEL (0x04) or AdES (0x05).
- take_exc suppresses the same-cycle MTC0 and ERET.
- On wb_valid & wb_is_eret & !take_exc: EXL = 0 next edge.
- exc_occur and eret_occur are combinational in the commit cycle; exactly one of the two may be high.
- MTC0 takes effect when mtc0_we & wb_valid & !take_exc. The new value is visible on mfc0_rdata the next cycle; there is no same-cycle bypass.
- Timer:
  - The toggle bit flips every cycle; Count += 1 (mod 2^32, wraps) when toggle=1.
  - TI is set on the edge where the post-increment Count equals Compare, and stays set.
  - An MTC0 to Compare clears TI and writes Compare; this has priority over a same-cycle match.
  - An MTC0 to Count loads mtc0_wdata, clears toggle, and suppresses that cycle's increment.
- Reset mid-operation: all state returns to reset values immediately; the pulses deassert asynchronously.

Test Plan:
- Reset, then read regs 12/13/14 -> mfc0_rdata = 32'h0040_0000, 0, 0; exc_occur=0.
- Commit wb_pc=32'hBFC0_1000, is_exc=1, excCode=0x0C (Ov), not in DS:
  - exc_occur=1 for 1 cycle, redirect_pc=32'hBFC0_0380.
  - Next cycle: EPC=32'hBFC0_1000, Cause=32'h0000_0030, Status.EXL=1.
- Delay-slot AdEL, wb_pc=32'h8000_0104, badvaddr=32'h0000_0003:
  - EPC=32'h8000_0100, Cause.BD=1, BadVAddr=32'h0000_0003.
  - A second exception while EXL=1 leaves EPC=32'h8000_0100.
- ERET commit with EPC=32'h8000_0200 -> eret_occur=1, redirect_pc=32'h8000_0200; next cycle Status.EXL=0.
- Timer:
  - MTC0 Count=0, Compare=5, Status=32'h0000_8001 -> TI sets after 10 cycles (Count reaches 5).
  - The next valid commit gives exc_occur=1 with ExcCode=0.
  - MTC0 Compare then clears TI.
- Same-cycle conflicts:
  - MTC0 Status on an instruction with is_exc=1 -> Status write dropped, EXL=1.
  - Count=32'hFFFF_FFFF -> wraps to 0 after two cycles.
